// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream register-read bundle and downstream operand bundle of the ALU issue stage
interface alu_issue_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [DATA_WIDTH-1:0] in_rs2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_lhs;
  logic [DATA_WIDTH-1:0] out_rhs;
  logic [2:0]            out_operation;
  logic [6:0]            out_metadata;
  logic [4:0]            out_rd;
  logic                  illegal;
  logic [15:0]           illegal_count;
  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_lhs, out_rhs, out_operation, out_metadata, out_rd,
           illegal, illegal_count
  );
  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_lhs, out_rhs, out_operation, out_metadata, out_rd,
           illegal, illegal_count
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: registered RV32I OP/OP-IMM issue stage; define ALU_ISSUE_SKID_EN for a two-entry skid buffer
module alu_issue #(
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic [2:0]            op;
    logic [6:0]            meta;
    logic [4:0]            rd;
  } bundle_t;
  logic [6:0]            opc, f7, meta;
  logic [2:0]            f3;
  logic                  is_op, is_imm, shift, legal, acc, ok;
  logic [DATA_WIDTH-1:0] rhs_raw;
  bundle_t               nb, m;
  logic                  m_valid;
  assign opc     = bus.in_instr[6:0];
  assign f3      = bus.in_instr[14:12];
  assign f7      = bus.in_instr[31:25];
  assign is_op   = opc == 7'b0110011;
  assign is_imm  = opc == 7'b0010011;
  assign shift   = f3 == 3'd1 || f3 == 3'd5;
  // immediate forms only carry funct7 for shifts, so ADDI with imm[10] never decodes as SUB
  assign meta    = (is_op || shift) ? f7 : 7'd0;
  assign rhs_raw = is_op ? bus.in_rs2 : {{(DATA_WIDTH-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign legal   = (is_op || is_imm) && (meta == 7'd0 || (meta == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
  assign acc     = bus.in_valid && bus.in_ready;
  assign ok      = acc && legal;
  assign nb      = '{lhs: bus.in_rs1,
                     rhs: shift ? {{(DATA_WIDTH-5){1'b0}}, rhs_raw[4:0]} : rhs_raw,
                     op: f3, meta: meta, rd: bus.in_instr[11:7]};
  assign bus.out_valid     = m_valid;
  assign bus.out_lhs       = m.lhs;
  assign bus.out_rhs       = m.rhs;
  assign bus.out_operation = m.op;
  assign bus.out_metadata  = m.meta;
  assign bus.out_rd        = m.rd;
  // illegal bundles are consumed: one-cycle pulse and a saturating count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.illegal       <= 1'b0;
      bus.illegal_count <= 16'd0;
    end else begin
      bus.illegal <= acc && !legal;
      if (acc && !legal && bus.illegal_count != 16'hFFFF) bus.illegal_count <= bus.illegal_count + 16'd1;
    end
  end
`ifdef ALU_ISSUE_SKID_EN
  bundle_t s;
  logic    s_valid, rdy;
  assign bus.in_ready = rdy;
  // main/skid pair: skid fills only while main is stalled and drains into main first, keeping order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m       <= '0;
      m_valid <= 1'b0;
      s       <= '0;
      s_valid <= 1'b0;
      rdy     <= 1'b1;
    end else if (!m_valid || bus.out_ready) begin
      m_valid <= s_valid || ok;
      m       <= s_valid ? s : ok ? nb : m;
      s_valid <= 1'b0;
      rdy     <= 1'b1;
    end else if (ok) begin
      s       <= nb;
      s_valid <= 1'b1;
      rdy     <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !m_valid || bus.out_ready;
  // single output register: reloads whenever it is empty or being drained this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m       <= '0;
      m_valid <= 1'b0;
    end else if (bus.in_ready) begin
      m_valid <= ok;
      if (ok) m <= nb;
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors, stall/reset sequences and randomized scoreboard for alu_issue
module tb_alu_issue;
  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [2:0]  op;
    logic [6:0]  meta;
    logic [4:0]  rd;
  } exp_t;
  typedef struct {
    logic [31:0] instr, rs1, rs2;
    logic        ok;
    exp_t        e;
  } vec_t;
  localparam int NV = 13;
  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0, errors = 0;
  bit    scb_on = 0, ill_pend = 0, mok;
  int    exp_cnt = 0, n_out = 0;
  exp_t  q[$];
  exp_t  me, fe;
  vec_t  tbl[NV];
  alu_issue_if #(.DATA_WIDTH(32)) bus();
  alu_issue #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference decode from the instruction-set rules: fields, immediate value, and the ten legal pairs
  function automatic bit model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, output exp_t e);
    bit [9:0] legal_set [10] = '{{3'd0, 7'h00}, {3'd0, 7'h20}, {3'd1, 7'h00}, {3'd2, 7'h00}, {3'd3, 7'h00},
                                 {3'd4, 7'h00}, {3'd5, 7'h00}, {3'd5, 7'h20}, {3'd6, 7'h00}, {3'd7, 7'h00}};
    int  f3 = int'(ins[14:12]);
    int  imm = int'(ins[31:20]);
    bit  sh = (f3 == 1 || f3 == 5);
    bit  found = 0;
    e.lhs = a;
    e.op  = ins[14:12];
    e.rd  = ins[11:7];
    if (ins[6:0] == 7'h33) begin
      e.rhs  = b;
      e.meta = ins[31:25];
    end else if (ins[6:0] == 7'h13) begin
      if (imm >= 2048) imm -= 4096;
      e.rhs  = imm;
      e.meta = sh ? ins[31:25] : 7'd0;
    end else begin
      e.rhs  = 0;
      e.meta = 0;
      return 0;
    end
    if (sh) e.rhs = e.rhs % 32;
    foreach (legal_set[k]) if (legal_set[k] == {e.op, e.meta}) found = 1;
    return found;
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 3);
    logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    if (k == 0) w[6:0] = 7'h33;
    if (k == 1 || k == 2) w[6:0] = 7'h13;
    if (k < 2) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction
  // scoreboard: pop before push so a bundle accepted this cycle is never compared against itself
  always @(negedge clk) if (scb_on) begin
    chk("illegal_pulse", bus.illegal, ill_pend);
    chk("illegal_count", bus.illegal_count, exp_cnt);
`ifndef ALU_ISSUE_SKID_EN
    chk("in_ready_comb", bus.in_ready, !bus.out_valid || bus.out_ready);
`endif
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got out_valid with lhs %h, expected no output", bus.out_lhs);
      end else begin
        fe = q.pop_front();
        n_out++;
        chk("sb_lhs", bus.out_lhs, fe.lhs);
        chk("sb_rhs", bus.out_rhs, fe.rhs);
        chk("sb_op", bus.out_operation, fe.op);
        chk("sb_meta", bus.out_metadata, fe.meta);
        chk("sb_rd", bus.out_rd, fe.rd);
      end
    end
    mok = model(bus.in_instr, bus.in_rs1, bus.in_rs2, me);
    ill_pend = bus.in_valid && bus.in_ready && !mok;
    if (ill_pend && exp_cnt != 65535) exp_cnt++;
    if (bus.in_valid && bus.in_ready && mok) q.push_back(me);
  end
  task automatic reset_dut();
    scb_on = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.in_instr = 0;
    bus.in_rs1 = 0;
    bus.in_rs2 = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic start_scb();
    q.delete();
    ill_pend = 0;
    exp_cnt = 0;
    n_out = 0;
    scb_on = 1;
  endtask
  task automatic drain();
    bus.in_valid = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1 scb_on = 0;
  endtask
  initial begin
    int sent, nill;
    tbl[0]  = '{32'h0000006F, 32'h1, 32'h2, 1'b0, '{32'h0, 32'h0, 3'd0, 7'h00, 5'd0}};
    tbl[1]  = '{32'h022081B3, 32'h1, 32'h2, 1'b0, '{32'h0, 32'h0, 3'd0, 7'h00, 5'd0}};
    tbl[2]  = '{32'h002081B3, 32'd5, 32'd7, 1'b1, '{32'd5, 32'd7, 3'd0, 7'h00, 5'd3}};
    tbl[3]  = '{32'h40000093, 32'h0, 32'h55, 1'b1, '{32'h0, 32'h400, 3'd0, 7'h00, 5'd1}};
    tbl[4]  = '{32'hFFF00293, 32'h11, 32'h0, 1'b1, '{32'h11, 32'hFFFFFFFF, 3'd0, 7'h00, 5'd5}};
    tbl[5]  = '{32'h40315093, 32'h80000000, 32'h9, 1'b1, '{32'h80000000, 32'd3, 3'd5, 7'h20, 5'd1}};
    tbl[6]  = '{32'h002091B3, 32'hA, 32'h25, 1'b1, '{32'hA, 32'd5, 3'd1, 7'h00, 5'd3}};
    tbl[7]  = '{32'h402081B3, 32'd9, 32'd4, 1'b1, '{32'd9, 32'd4, 3'd0, 7'h20, 5'd3}};
    tbl[8]  = '{32'h40309093, 32'h1, 32'h2, 1'b0, '{32'h0, 32'h0, 3'd0, 7'h00, 5'd0}};
    tbl[9]  = '{32'h00208033, 32'd1, 32'd2, 1'b1, '{32'd1, 32'd2, 3'd0, 7'h00, 5'd0}};
    tbl[10] = '{32'h7FF0B313, 32'd3, 32'h0, 1'b1, '{32'd3, 32'h7FF, 3'd3, 7'h00, 5'd6}};
    tbl[11] = '{32'h0020D1B3, 32'h80, 32'hFFFFFFE3, 1'b1, '{32'h80, 32'd3, 3'd5, 7'h00, 5'd3}};
    tbl[12] = '{32'h12345037, 32'h1, 32'h2, 1'b0, '{32'h0, 32'h0, 3'd0, 7'h00, 5'd0}};
    reset_dut();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_lhs", bus.out_lhs, 0);
    chk("rst_rhs", bus.out_rhs, 0);
    chk("rst_meta", {bus.out_operation, bus.out_metadata, bus.out_rd}, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_count", bus.illegal_count, 0);
    nill = 0;
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1;
      bus.in_instr = tbl[i].instr;
      bus.in_rs1 = tbl[i].rs1;
      bus.in_rs2 = tbl[i].rs2;
      bus.out_ready = 1;
      @(posedge clk);
      #1 bus.in_valid = 0;
      if (!tbl[i].ok) nill++;
      chk($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].ok);
      chk($sformatf("v%0d_illegal", i), bus.illegal, !tbl[i].ok);
      if (tbl[i].ok) begin
        chk($sformatf("v%0d_lhs", i), bus.out_lhs, tbl[i].e.lhs);
        chk($sformatf("v%0d_rhs", i), bus.out_rhs, tbl[i].e.rhs);
        chk($sformatf("v%0d_op", i), bus.out_operation, tbl[i].e.op);
        chk($sformatf("v%0d_meta", i), bus.out_metadata, tbl[i].e.meta);
        chk($sformatf("v%0d_rd", i), bus.out_rd, tbl[i].e.rd);
      end
      if (i == 1) chk("count_two", bus.illegal_count, 2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_end", i), bus.illegal, 0);
    end
    chk("count_table", bus.illegal_count, nill);
    reset_dut();
    start_scb();
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      bus.in_valid = 1;
      bus.in_instr = 32'h002081B3;
      bus.in_rs1 = 100 + sent;
      bus.in_rs2 = sent;
      bus.out_ready = !(c == 3 || c == 4);
      @(negedge clk);
`ifdef ALU_ISSUE_SKID_EN
      if (c == 3) chk("skid_ready_in_stall", bus.in_ready, 1);
`endif
      if (bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    drain();
    chk("stream_sent", sent, 8);
    chk("stream_out", n_out, 8);
    reset_dut();
    start_scb();
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_instr = rnd_instr();
      bus.in_rs1 = $urandom;
      bus.in_rs2 = $urandom;
      bus.out_ready = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
    end
    drain();
    reset_dut();
    bus.in_valid = 1;
    bus.in_instr = 32'h002081B3;
    bus.in_rs1 = 32'd42;
    bus.in_rs2 = 32'd1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    chk("stall_valid", bus.out_valid, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_lhs", bus.out_lhs, 0);
    @(posedge clk);
    #1 rst = 1;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_valid", bus.out_valid, 0);
    bus.in_valid = 1;
    bus.in_rs1 = 32'd9;
    @(posedge clk);
    #1 bus.in_valid = 0;
    chk("post_rst_new_valid", bus.out_valid, 1);
    chk("post_rst_new_lhs", bus.out_lhs, 9);
    reset_dut();
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.in_instr = 32'h0000006F;
    repeat (65535) @(posedge clk);
    #1;
    chk("count_reach_max", bus.illegal_count, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 0;
    chk("count_saturate", bus.illegal_count, 16'hFFFF);
    chk("no_out_for_illegal", bus.out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Registered issue stage directly upstream of the integer `arithmetic` unit. It accepts a decoded-register-read bundle: the raw RV32I instruction word plus the rs1/rs2 values. For OP (0110011) and OP-IMM (0010011) instructions it produces the `lhs`/`rhs`/`operation`/`metadata` operand set the arithmetic unit consumes, plus the destination register. It has ready/valid handshakes on both sides, drops illegal encodings with a pulse and a counter, and optionally has a skid buffer to break the ready path.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand width. Values other than 32 are unsupported.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  upstream bundle valid.
- `in_ready`  output  1  stage can accept; transfer when `in_valid && in_ready`.
- `in_instr`  input  32  instruction word.
- `in_rs1`  input  DATA_WIDTH  rs1 register value.
- `in_rs2`  input  DATA_WIDTH  rs2 register value.
- `out_valid`  output  1  operand bundle valid.
- `out_ready`  input  1  arithmetic/writeback side accepts.
- `out_lhs`  output  DATA_WIDTH  to `lhs`.
- `out_rhs`  output  DATA_WIDTH  to `rhs`.
- `out_operation`  output  3  funct3, to `operation`.
- `out_metadata`  output  7  to `metadata`.
- `out_rd`  output  5  destination register index.
- `illegal`  output  1  one-cycle pulse when an illegal bundle is consumed.
- `illegal_count`  output  16  saturating count of illegal bundles.

## Operation
- **OP:**
  - `lhs` = rs1; `rhs` = rs2; `operation` = funct3; `metadata` = funct7.
- **OP-IMM:**
  - `lhs` = rs1; `rhs` = sign-extended instr[31:20]; `operation` = funct3.
  - `metadata` = instr[31:25] only for funct3 1 and 5; otherwise 0. ADDI with imm[10] set must not become SUB.
- **Shifts (funct3 1/5, both forms):** `rhs` is masked to bits [4:0], zero-extended.
- **Legal set:** exactly the ten (funct3, metadata) pairs the arithmetic unit accepts: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Legal OP-IMM pairs are those same pairs after the metadata rule above.
- **Illegal bundles:** anything else (other opcodes, bad funct7) is consumed, never forwarded.
  - `illegal` pulses in the cycle after acceptance.
  - `illegal_count` increments and saturates at 0xFFFF.
- **Forwarding:** rd = 0 is forwarded normally (writeback discards x0).
- **Output stability:** payload is held stable while `out_valid && !out_ready`.

## Timing
- **Reset** (async assert, sync release by register):
  - `out_valid`=0, `in_ready`=1.
  - All `out_*` payload = 0, `illegal`=0, `illegal_count`=0.
- **Latency:** a bundle accepted in cycle N presents `out_valid`=1 in cycle N+1.
- **Throughput:** one bundle per cycle when `out_ready` stays high.
- **Simultaneous events:**
  - Acceptance and output transfer in the same cycle: the new bundle replaces the old one with no bubble.
  - Illegal acceptance while the output is stalled: the output is unchanged and only `illegal`/count update.
- **Reset mid-operation:** all held bundles are discarded; `out_valid` drops immediately on `rst` assertion.
- `in_ready` behaviour depends on configuration (below).

## Configuration
- **`ALU_ISSUE_SKID_EN` defined:**
  - Two-entry buffer (main + skid).
  - `in_ready` is a register output equal to "skid entry empty", with no combinational path from `out_ready`.
  - A bundle arriving while main is stalled goes to skid. On drain, skid moves to main in order.
  - Full throughput is sustained across single-cycle `out_ready` drops.
- **Undefined:**
  - Single register.
  - `in_ready = !out_valid || out_ready`, a combinational path.
- Illegal handling and data results are identical in both builds.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, `out_ready`=1 -> next cycle: lhs=5, rhs=7, operation=0, metadata=0x00, rd=3.
- ADDI x1,x0,0x400 (0x40000093), rs1=0 -> rhs=0x00000400, metadata=0x00; ADDI x5,x0,-1 (0xFFF00293) -> rhs=0xFFFFFFFF, rd=5.
- Shifts:
  - SRAI x1,x2,3 (0x40315093), rs1=0x80000000 -> rhs=3, operation=5, metadata=0x20.
  - SLL reg-form with rs2=0x00000025 -> rhs=5.
- JAL 0x0000006F, then ADD with funct7=0x01 -> no `out_valid`, two `illegal` pulses, `illegal_count`=2. With the counter preloaded by 65535 illegals, it stays 0xFFFF.
- Back-to-back stream of 8 ADDs with `out_ready` low for cycles 3 and 4 -> all 8 emerge in order with no loss or duplication.
  - Skid build: `in_ready` stays high through a single-cycle stall.
  - Non-skid build: `in_ready` tracks `out_ready` when full.
- `rst` asserted while `out_valid`=1 and stalled -> `out_valid` drops asynchronously; after release, `in_ready`=1 and the first new bundle appears one cycle after acceptance.
